// File: rtl/core_pkg.sv
// Shared memory-control encodings and the load/store unit state type.
// Also holds small helpers for access masks and split detection.
package core_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    MAU_IDLE  = 2'd0,
    MAU_BEAT0 = 2'd1,
    MAU_BEAT1 = 2'd2,
    MAU_RESP  = 2'd3
  } mau_state_t;

  // Encoding 2'b11 behaves as a word access.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      MEM_BYTE: return 4'h1;
      MEM_HALF: return 4'h3;
      default:  return 4'hF;
    endcase
  endfunction

  function automatic logic is_split(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return (off == 2'd3);
      default:  return (off != 2'd0);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bus between the core and the load/store unit, plus the
// word-SRAM port the unit drives.
interface mem_access_unit_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              resp_valid;
  logic [31:0]       rdata;
  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-3:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  modport slave (
    input  req_valid, mem_read, mem_write, mem_size, mem_unsigned, addr, wdata,
    output req_ready, resp_valid, rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output req_valid, mem_read, mem_write, mem_size, mem_unsigned, addr, wdata,
    input  req_ready, resp_valid, rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables/data across two words, and the
// load-side shift plus sign/zero extension.
module mem_lane_align
  import core_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        unsigned_ld,
  input  logic [31:0] wdata,
  input  logic [63:0] r64,
  output logic [7:0]  be64,
  output logic [63:0] w64,
  output logic [31:0] rdata
);
  logic [31:0] r_low;
  logic        fill;

  assign be64  = {4'b0000, size_mask(size)} << off;
  assign w64   = {32'b0, wdata} << {off, 3'b000};
  assign r_low = 32'(r64 >> {off, 3'b000});

  always_comb begin
    rdata = r_low;
    fill  = 1'b0;
    case (size)
      MEM_BYTE: begin
        fill  = ~unsigned_ld & r_low[7];
        rdata = {{24{fill}}, r_low[7:0]};
      end
      MEM_HALF: begin
        fill  = ~unsigned_ld & r_low[15];
        rdata = {{16{fill}}, r_low[15:0]};
      end
      default: rdata = r_low;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store responder in front of a 1-cycle word SRAM;
// misaligned halves/words are issued as two consecutive SRAM beats.
module mem_access_unit
  import core_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);
  localparam int WA_W = ADDR_W - 2;

  mau_state_t        state_reg, state_next;
  logic [1:0]        size_reg;
  logic              unsigned_reg;
  logic              store_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       hold_reg;

  logic              accept;
  logic              split;
  logic [1:0]        off;
  logic [WA_W-1:0]   word_addr;
  logic [7:0]        be64;
  logic [63:0]       w64;
  logic [63:0]       r64;
  logic [31:0]       load_data;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^bus.addr[31:ADDR_W];

  assign accept    = bus.req_valid & (state_reg == MAU_IDLE) & (bus.mem_read | bus.mem_write);
  assign off       = addr_reg[1:0];
  assign split     = is_split(size_reg, off);
  assign word_addr = addr_reg[ADDR_W-1:2];
  // BEAT0 data was parked in hold_reg; the second word arrives in RESP.
  assign r64       = split ? {bus.sram_rdata, hold_reg} : {32'b0, bus.sram_rdata};

  mem_lane_align u_align (
    .size        (size_reg),
    .off         (off),
    .unsigned_ld (unsigned_reg),
    .wdata       (wdata_reg),
    .r64         (r64),
    .be64        (be64),
    .w64         (w64),
    .rdata       (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= MAU_IDLE;
      size_reg     <= MEM_BYTE;
      unsigned_reg <= 1'b0;
      store_reg    <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      hold_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        size_reg     <= bus.mem_size;
        unsigned_reg <= bus.mem_unsigned;
        store_reg    <= bus.mem_write;
        addr_reg     <= bus.addr[ADDR_W-1:0];
        wdata_reg    <= bus.wdata;
      end
      if (state_reg == MAU_BEAT1) hold_reg <= bus.sram_rdata;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MAU_IDLE:  if (accept) state_next = MAU_BEAT0;
      MAU_BEAT0: state_next = split ? MAU_BEAT1 : MAU_RESP;
      MAU_BEAT1: state_next = MAU_RESP;
      MAU_RESP:  state_next = MAU_IDLE;
      default:   state_next = MAU_IDLE;
    endcase
  end

  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_we    = 4'h0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    case (state_reg)
      MAU_BEAT0: begin
        bus.sram_en    = 1'b1;
        bus.sram_we    = store_reg ? be64[3:0] : 4'h0;
        bus.sram_addr  = word_addr;
        bus.sram_wdata = store_reg ? w64[31:0] : 32'h0;
      end
      MAU_BEAT1: begin
        bus.sram_en    = 1'b1;
        bus.sram_we    = store_reg ? be64[7:4] : 4'h0;
        bus.sram_addr  = word_addr + WA_W'(1);
        bus.sram_wdata = store_reg ? w64[63:32] : 32'h0;
      end
      default: ;
    endcase
  end

  assign bus.req_ready  = (state_reg == MAU_IDLE);
  assign bus.resp_valid = (state_reg == MAU_RESP);
  assign bus.rdata      = ((state_reg == MAU_RESP) && !store_reg) ? load_data : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 1-cycle word SRAM.
module tb_mem_access_unit;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] sram [0:(1<<(ADDR_W-2))-1];

  always @(posedge clk) begin
    if (bus.sram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.sram_we[b]) sram[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      bus.sram_rdata <= sram[bus.sram_addr];
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [1:0] size,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.mem_read     = rd;
    bus.mem_write    = wr;
    bus.mem_size     = size;
    bus.mem_unsigned = uns;
    bus.addr         = a;
    bus.wdata        = wd;
    $display("txn t=%0t rd=%0d wr=%0d size=%0d uns=%0d addr=%h wdata=%h",
             $time, rd, wr, size, uns, a, wd);
  endtask

  // Called at a negedge while idle; returns at the negedge after the accept edge.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] size,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    drive(rd, wr, size, uns, a, wd);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_store(input logic [31:0] a, input logic [31:0] wd);
    issue(1'b0, 1'b1, 2'b10, 1'b0, a, wd);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.mem_size = 2'b00; bus.mem_unsigned = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.sram_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_assert++; if (bus.sram_en !== 1'b0) begin n_fail++; $display("FAIL rst_en got %b want 0", bus.sram_en); end
    n_assert++; if (bus.sram_we !== 4'h0) begin n_fail++; $display("FAIL rst_we got %h want 0", bus.sram_we); end
    n_assert++; if (bus.sram_addr !== 14'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", bus.sram_addr); end
    n_assert++; if (bus.sram_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got %h want 0", bus.sram_wdata); end
    n_assert++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp got %b want 0", bus.resp_valid); end
    n_assert++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", bus.rdata); end
    n_assert++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_word;
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF);
    n_assert++; if (bus.sram_en !== 1'b1) begin n_fail++; $display("FAIL sw_en got %b want 1", bus.sram_en); end
    n_assert++; if (bus.sram_we !== 4'hF) begin n_fail++; $display("FAIL sw_we got %h want f", bus.sram_we); end
    n_assert++; if (bus.sram_addr !== 14'h2) begin n_fail++; $display("FAIL sw_addr got %h want 2", bus.sram_addr); end
    n_assert++; if (bus.sram_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata got %h want deadbeef", bus.sram_wdata); end
    n_assert++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL sw_busy got %b want 0", bus.req_ready); end
    @(negedge clk);
    n_assert++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL sw_resp got %b want 1", bus.resp_valid); end
    n_assert++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL sw_rdata got %h want 0", bus.rdata); end
    @(negedge clk);
    n_assert++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL sw_ready got %b want 1", bus.req_ready); end
    n_assert++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL sw_resp_drop got %b want 0", bus.resp_valid); end
  endtask

  task automatic test_load_byte;
    run_store(32'h0000_0004, 32'h1122_8344);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0005, 32'h0);
    n_assert++; if (bus.sram_we !== 4'h0 || bus.sram_addr !== 14'h1) begin n_fail++; $display("FAIL lb_beat0 got we=%h addr=%h want we=0 addr=1", bus.sram_we, bus.sram_addr); end
    @(negedge clk);
    n_assert++; if (bus.resp_valid !== 1'b1 || bus.rdata !== 32'hFFFF_FF83) begin n_fail++; $display("FAIL lb_rdata got v=%b %h want v=1 ffffff83", bus.resp_valid, bus.rdata); end
    @(negedge clk);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0005, 32'h0);
    @(negedge clk);
    n_assert++; if (bus.resp_valid !== 1'b1 || bus.rdata !== 32'h0000_0083) begin n_fail++; $display("FAIL lbu_rdata got v=%b %h want v=1 00000083", bus.resp_valid, bus.rdata); end
    @(negedge clk);
  endtask

  task automatic test_split_load;
    run_store(32'h0000_0004, 32'hAABB_CCDD);
    run_store(32'h0000_0008, 32'h1122_3344);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
    n_assert++; if (bus.sram_en !== 1'b1 || bus.sram_we !== 4'h0 || bus.sram_addr !== 14'h1) begin n_fail++; $display("FAIL lw_split_b0 got en=%b we=%h addr=%h want 1/0/1", bus.sram_en, bus.sram_we, bus.sram_addr); end
    @(negedge clk);
    n_assert++; if (bus.sram_en !== 1'b1 || bus.sram_we !== 4'h0 || bus.sram_addr !== 14'h2) begin n_fail++; $display("FAIL lw_split_b1 got en=%b we=%h addr=%h want 1/0/2", bus.sram_en, bus.sram_we, bus.sram_addr); end
    n_assert++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL lw_split_early got %b want 0", bus.resp_valid); end
    @(negedge clk);
    n_assert++; if (bus.resp_valid !== 1'b1 || bus.rdata !== 32'h3344_AABB) begin n_fail++; $display("FAIL lw_split_rdata got v=%b %h want v=1 3344aabb", bus.resp_valid, bus.rdata); end
    @(negedge clk);
  endtask

  task automatic test_split_store;
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h0000_A55A);
    n_assert++; if (bus.sram_addr !== 14'h0 || bus.sram_we !== 4'h8 || bus.sram_wdata[31:24] !== 8'h5A) begin n_fail++; $display("FAIL sh_b0 got addr=%h we=%h wd=%h want 0/8/5a......", bus.sram_addr, bus.sram_we, bus.sram_wdata); end
    @(negedge clk);
    n_assert++; if (bus.sram_addr !== 14'h1 || bus.sram_we !== 4'h1 || bus.sram_wdata[7:0] !== 8'hA5) begin n_fail++; $display("FAIL sh_b1 got addr=%h we=%h wd=%h want 1/1/......a5", bus.sram_addr, bus.sram_we, bus.sram_wdata); end
    @(negedge clk);
    n_assert++; if (bus.resp_valid !== 1'b1 || bus.rdata !== 32'h0) begin n_fail++; $display("FAIL sh_resp got v=%b %h want v=1 0", bus.resp_valid, bus.rdata); end
    @(negedge clk);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0);
    repeat (2) @(negedge clk);
    n_assert++; if (bus.resp_valid !== 1'b1 || bus.rdata !== 32'hFFFF_A55A) begin n_fail++; $display("FAIL lh_split got v=%b %h want v=1 ffffa55a", bus.resp_valid, bus.rdata); end
    @(negedge clk);
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0003, 32'h0);
    repeat (2) @(negedge clk);
    n_assert++; if (bus.resp_valid !== 1'b1 || bus.rdata !== 32'h0000_A55A) begin n_fail++; $display("FAIL lhu_split got v=%b %h want v=1 0000a55a", bus.resp_valid, bus.rdata); end
    @(negedge clk);
  endtask

  task automatic test_read_write_both;
    issue(1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'hCAFE_F00D);
    n_assert++; if (bus.sram_we !== 4'hF || bus.sram_addr !== 14'h4 || bus.sram_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rw_store got we=%h addr=%h wd=%h want f/4/cafef00d", bus.sram_we, bus.sram_addr, bus.sram_wdata); end
    repeat (2) @(negedge clk);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    n_assert++; if (bus.rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lw_aligned got %h want cafef00d", bus.rdata); end
    @(negedge clk);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0);
    @(negedge clk);
    n_assert++; if (bus.resp_valid !== 1'b1 || bus.rdata !== 32'hFFFF_CAFE) begin n_fail++; $display("FAIL lh_upper got v=%b %h want v=1 ffffcafe", bus.resp_valid, bus.rdata); end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    run_store(32'h0000_FFFC, 32'h1234_5678);
    run_store(32'h0000_0000, 32'h9ABC_DEF0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_FFFE, 32'h0);
    n_assert++; if (bus.sram_addr !== 14'h3FFF) begin n_fail++; $display("FAIL wrap_b0 got %h want 3fff", bus.sram_addr); end
    @(negedge clk);
    n_assert++; if (bus.sram_addr !== 14'h0000 || bus.sram_en !== 1'b1) begin n_fail++; $display("FAIL wrap_b1 got addr=%h en=%b want 0000/1", bus.sram_addr, bus.sram_en); end
    @(negedge clk);
    n_assert++; if (bus.resp_valid !== 1'b1 || bus.rdata !== 32'hDEF0_1234) begin n_fail++; $display("FAIL wrap_rdata got v=%b %h want v=1 def01234", bus.resp_valid, bus.rdata); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h0102_0304);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0021, 32'h0);
    @(negedge clk);
    n_assert++; if (bus.req_ready !== 1'b1 || bus.sram_en !== 1'b0) begin n_fail++; $display("FAIL b2b_hold got ready=%b en=%b want 1/0", bus.req_ready, bus.sram_en); end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    n_assert++; if (bus.sram_en !== 1'b1 || bus.sram_addr !== 14'h8) begin n_fail++; $display("FAIL b2b_beat got en=%b addr=%h want 1/8", bus.sram_en, bus.sram_addr); end
    @(negedge clk);
    n_assert++; if (bus.resp_valid !== 1'b1 || bus.rdata !== 32'h0000_0003) begin n_fail++; $display("FAIL b2b_rdata got v=%b %h want v=1 00000003", bus.resp_valid, bus.rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight;
    int seen;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_assert++; if (bus.sram_en !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst got en=%b ready=%b resp=%b want 0/1/0", bus.sram_en, bus.req_ready, bus.resp_valid); end
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    n_assert++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_resp got %0d pulses want 0", seen); end
  endtask

  task automatic test_ignored;
    int seen;
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    n_assert++; if (bus.sram_en !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL ignored got en=%b ready=%b want 0/1", bus.sram_en, bus.req_ready); end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid || bus.sram_en) seen++;
    end
    n_assert++; if (seen !== 0) begin n_fail++; $display("FAIL ignored_activity got %0d want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_split_load();
    test_split_store();
    test_read_write_both();
    test_wrap();
    test_back_to_back();
    test_reset_midflight();
    test_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Data-memory responder for the memory-control signals the decoder produces: mem_read, mem_write, mem_size and mem_unsigned. It accepts one load/store request at a time and drives a 1-cycle-latency synchronous word SRAM with byte enables. Misaligned halfword and word accesses are split into two SRAM beats. For loads it returns the sign- or zero-extended result, and for stores it returns a completion pulse; the core stalls while req_ready is low.

Parameters:
ADDR_W, 16, number of byte-address bits used (SRAM word address is ADDR_W-2 bits)

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  unit idle and can accept
mem_read  in  1  load request
mem_write  in  1  store request
mem_size  in  2  00=byte, 01=half, 10=word, 11=treated as word
mem_unsigned  in  1  zero-extend load result
addr  in  32  byte address; only [ADDR_W-1:0] is used
wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse (loads and stores)
rdata  out  32  extended load data, valid with resp_valid
sram_en  out  1  SRAM access this cycle
sram_we  out  4  byte write enables (0 = read)
sram_addr  out  ADDR_W-2  word address
sram_wdata  out  32  byte-lane-aligned write data
sram_rdata  in  32  read data, valid the cycle after sram_en

Behaviour:
- States: IDLE, BEAT0, BEAT1, RESP. Reset (rst_n=0 at a clk edge) forces IDLE; any in-flight access is discarded with no response.
- Reset values: sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, resp_valid=0, rdata=0. req_ready=1 one cycle after reset.
- req_ready = (state==IDLE).
- Acceptance: accept when req_valid & req_ready & (mem_read|mem_write); latch all request fields.
  - req_valid with neither mem_read nor mem_write: ignored, no response.
  - mem_read & mem_write together: treated as a store.
- Transitions:
  - IDLE -> BEAT0 on accept.
  - BEAT0 -> BEAT1 if split, else RESP.
  - BEAT1 -> RESP.
  - RESP -> IDLE.
- SRAM ports are driven only from latched state; there is no combinational path from request inputs to SRAM outputs. sram_en=1 only in BEAT0/BEAT1.
- off = addr[1:0]. split = (half & off==3) | (word & off!=0). A byte access never splits.
- mask: byte=0x1, half=0x3, word=0xF. be64 = mask << off.
  - BEAT0: we = be64[3:0], addr = addr[ADDR_W-1:2].
  - BEAT1: we = be64[7:4], addr = addr[ADDR_W-1:2]+1, wrapping modulo 2^(ADDR_W-2).
- Writes: w64 = {32'b0,wdata} << 8*off. BEAT0 drives w64[31:0]; BEAT1 drives w64[63:32]. For loads sram_we=0.
- Reads:
  - BEAT0 data is captured in BEAT1 (split case) into a hold register.
  - In RESP: r64 = {sram_rdata, hold} when split, else {32'b0, sram_rdata}. Then shift r64 >> 8*off.
  - Extend the low byte/half/word by mem_unsigned: sign-extend when 0, zero-extend when 1.
- Latency from accept edge T: aligned access resp_valid at T+2; split access at T+3.
- resp_valid=1 only in RESP. rdata equals the load result in RESP for loads; rdata=0 in all other cycles and for stores.
- Back-to-back requests: the next accept is possible in the cycle after RESP.
- Requests with req_valid high while req_ready=0 are not latched; the requester must hold them.

Decomposition:
- Shared package core_pkg: mem_size encodings MEM_BYTE/MEM_HALF/MEM_WORD (identical to the decoder's), and the state encoding for this unit.
- Sub-module mem_lane_align (combinational) computes be64/w64 from size/off/wdata and performs read shift plus extension. The FSM and registers stay in mem_access_unit.

Test Plan:
- sw addr 0x0008 wdata 0xDEADBEEF accepted at T -> T+1 sram_en=1, we=0xF, addr=2, wdata=0xDEADBEEF; resp_valid at T+2, rdata=0.
- Preload word1=0x11228344; lb addr 0x0005 -> rdata 0xFFFFFF83 at T+2; lbu same addr -> 0x00000083.
- Preload word1=0xAABBCCDD, word2=0x11223344; lw addr 0x0006 -> BEAT0 addr1 we=0 then BEAT1 addr2; resp_valid at T+3 with rdata 0x3344AABB.
- sh addr 0x0003 wdata 0x0000A55A -> BEAT0 addr0 we=0x8 wdata[31:24]=0x5A; BEAT1 addr1 we=0x1 wdata[7:0]=0xA5.
- lw addr 0xFFFE (ADDR_W=16) -> BEAT0 addr 0x3FFF, BEAT1 addr 0x0000 (wrap).
- rst_n=0 during BEAT1 of a split lw -> next cycle sram_en=0, req_ready=1, resp_valid never asserted; request with mem_read=mem_write=0 -> no sram_en, no response.
